vpu_inst_sched: RTL

Instruction scheduler in front of the VPU. Buffers 32-bit VPU instructions from the host/controller in a small FIFO and dispatches them one at a time to the VPU core. Each dispatch is a single-cycle start pulse; the scheduler waits for the VPU's done pulse before issuing the next instruction. Reports queue level, busy and retired-instruction count, and retires NOPs locally.

---
 rtl/vpu_inst_sched.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vpu_inst_sched.sv
// VPU instruction scheduler: FIFO-buffered, one-at-a-time dispatch with start/done handshake.
// Optional watchdog (WAIT timeout -> sticky error + HALT) enabled by `define VPU_SCHED_TIMEOUT_EN.
module vpu_inst_sched #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        inst_in,
  input  logic                     inst_valid,
  output logic                     inst_ready,
  input  logic                     flush,
  output logic [DATA_W-1:0]        vpu_inst,
  output logic                     vpu_start,
  input  logic                     vpu_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         retired_cnt,
  output logic                     err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_RETIRE = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t state, state_nxt;

  // ---------------- instruction FIFO ----------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       cnt;
  logic              full, empty, push, pop;
  logic [DATA_W-1:0] head;

  assign full  = (cnt == FULL_LVL);
  assign empty = (cnt == '0);
  assign head  = mem[rd_ptr];

  // flush wins over a same-cycle enqueue and blocks the pop so nothing queued escapes
  assign push = inst_valid && !full && !flush;
  assign pop  = (state == S_IDLE) && !empty && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= inst_in;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // ---------------- watchdog ----------------
`ifdef VPU_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int TO_LAST_I = TIMEOUT_CYC - 1;
  localparam logic [TW-1:0] TO_LAST = TO_LAST_I[TW-1:0];

  logic [TW-1:0] wait_cnt;
  logic          to_hit;

  // limit reached on the last permitted WAIT cycle; a same-cycle done takes priority
  assign to_hit = (state == S_WAIT) && !vpu_done && (wait_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == S_ISSUE)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (to_hit) err_timeout <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (pop) state_nxt = (head[3:0] == 4'h0) ? S_RETIRE : S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (vpu_done) state_nxt = S_RETIRE;
`ifdef VPU_SCHED_TIMEOUT_EN
        else if (to_hit) state_nxt = S_HALT;
`endif
      end
      S_RETIRE: state_nxt = S_IDLE;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    vpu_start  = (state == S_ISSUE);
    busy       = (state != S_IDLE) || !empty;
    inst_ready = !full;
    level      = cnt;
  end

  // vpu_inst is only reloaded on a pop, so it stays put through ISSUE/WAIT/RETIRE and after
  always_ff @(posedge clk) begin
    if (rst) begin
      vpu_inst    <= '0;
      retired_cnt <= '0;
    end else begin
      if (pop) vpu_inst <= head;
      if (state == S_RETIRE) retired_cnt <= retired_cnt + 1'b1;
    end
  end

endmodule
